// File: rtl/fmul_result_stage.sv
// Registered 2-entry skid-buffer output stage for the fmul result, with result
// classification and sticky/counted overflow status. Optional: FMUL_NAN_CANON_EN.
module fmul_result_stage #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_y,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic             out_ovf,
  output logic [2:0]       out_cls,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             flag_clr
);

  localparam logic [2:0] CLS_ZERO   = 3'd0;
  localparam logic [2:0] CLS_NORMAL = 3'd1;
  localparam logic [2:0] CLS_INF    = 3'd2;
  localparam logic [2:0] CLS_NAN    = 3'd3;
  localparam logic [2:0] CLS_DENORM = 3'd4;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  logic [1:0]       r_occ;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [31:0]      r_head_y;
  logic             r_head_ovf;
  logic [2:0]       r_head_cls;
  logic [31:0]      r_skid_y;
  logic             r_skid_ovf;
  logic [2:0]       r_skid_cls;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;

  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_exp;
  logic [22:0]      w_man;
  logic [2:0]       w_cls;
  logic [31:0]      w_y;
  logic [1:0]       w_occ_nxt;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;
  assign w_exp  = in_y[30:23];
  assign w_man  = in_y[22:0];

  always_comb begin
    w_cls = CLS_NORMAL;
    if (w_exp == 8'h00) begin
      w_cls = (w_man == '0) ? CLS_ZERO : CLS_DENORM;
    end else if (w_exp == 8'hFF) begin
      w_cls = (w_man == '0) ? CLS_INF : CLS_NAN;
    end
  end

`ifdef FMUL_NAN_CANON_EN
  assign w_y = (w_cls == CLS_NAN) ? 32'h7FC0_0000 : in_y;
`else
  assign w_y = in_y;
`endif

  always_comb begin
    w_occ_nxt = r_occ;
    case (r_occ)
      OCC_EMPTY: if (w_push) w_occ_nxt = OCC_ONE;
      OCC_ONE: begin
        if (w_push && !w_pop)      w_occ_nxt = OCC_FULL;
        else if (!w_push && w_pop) w_occ_nxt = OCC_EMPTY;
      end
      OCC_FULL:  if (w_pop) w_occ_nxt = OCC_ONE;
      default:   w_occ_nxt = OCC_EMPTY;
    endcase
  end

  // Head is the output register; the skid entry only fills when head is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ       <= OCC_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head_y    <= '0;
      r_head_ovf  <= 1'b0;
      r_head_cls  <= CLS_ZERO;
      r_skid_y    <= '0;
      r_skid_ovf  <= 1'b0;
      r_skid_cls  <= CLS_ZERO;
    end else begin
      r_occ       <= w_occ_nxt;
      r_in_ready  <= (w_occ_nxt != OCC_FULL);
      r_out_valid <= (w_occ_nxt != OCC_EMPTY);
      case (r_occ)
        OCC_EMPTY: begin
          if (w_push) begin
            r_head_y   <= w_y;
            r_head_ovf <= in_ovf;
            r_head_cls <= w_cls;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_head_y   <= w_y;
            r_head_ovf <= in_ovf;
            r_head_cls <= w_cls;
          end else if (w_push) begin
            r_skid_y   <= w_y;
            r_skid_ovf <= in_ovf;
            r_skid_cls <= w_cls;
          end
        end
        OCC_FULL: begin
          if (w_pop) begin
            r_head_y   <= r_skid_y;
            r_head_ovf <= r_skid_ovf;
            r_head_cls <= r_skid_cls;
          end
        end
        default: ;
      endcase
    end
  end

  // An overflow accept outranks a simultaneous clear: the event restarts the count at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (w_push && in_ovf) begin
      r_sticky <= 1'b1;
      if (flag_clr)          r_cnt <= CNT_W'(1);
      else if (r_cnt != '1)  r_cnt <= r_cnt + CNT_W'(1);
    end else if (flag_clr) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_y      = r_head_y;
  assign out_ovf    = r_head_ovf;
  assign out_cls    = r_head_cls;
  assign ovf_sticky = r_sticky;
  assign ovf_cnt    = r_cnt;

endmodule

// File: tb/tb_fmul_result_stage.sv
// Self-checking bench for fmul_result_stage: directed scenarios plus randomized
// traffic against a queue-based reference model. Honors FMUL_NAN_CANON_EN.
module tb_fmul_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_y;
  logic        in_ovf;
  logic        out_ready;
  logic        flag_clr;

  logic        in_ready, out_valid, out_ovf, ovf_sticky;
  logic [31:0] out_y;
  logic [2:0]  out_cls;
  logic [7:0]  ovf_cnt;

  logic        s_in_ready, s_out_valid, s_out_ovf, s_ovf_sticky;
  logic [31:0] s_out_y;
  logic [2:0]  s_out_cls;
  logic [1:0]  s_ovf_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq_y[$];
  logic        mq_o[$];
  int          mq_c[$];
  bit          m_sticky;
  int          m_cnt;
  int          m_cnt2;

  always #5 clk = ~clk;

  fmul_result_stage #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_ovf(in_ovf), .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_ovf(out_ovf), .out_cls(out_cls),
    .ovf_sticky(ovf_sticky), .ovf_cnt(ovf_cnt), .flag_clr(flag_clr)
  );

  fmul_result_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_y(in_y), .in_ovf(in_ovf), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_y(s_out_y), .out_ovf(s_out_ovf), .out_cls(s_out_cls),
    .ovf_sticky(s_ovf_sticky), .ovf_cnt(s_ovf_cnt), .flag_clr(flag_clr)
  );

  function automatic int m_class(input logic [31:0] y);
    int e, m;
    e = (y >> 23) % 256;
    m = y % (1 << 23);
    if (e == 0)   return (m == 0) ? 0 : 4;
    if (e == 255) return (m == 0) ? 2 : 3;
    return 1;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] y);
`ifdef FMUL_NAN_CANON_EN
    if (m_class(y) == 3) return 32'h7FC00000;
`endif
    return y;
  endfunction

  // Advance one clock; the model applies the same edge's accept/pop/flag rules.
  task automatic tick();
    bit acc, pop;
    acc = !rst && in_valid && (mq_y.size() < 2);
    pop = !rst && (mq_y.size() > 0) && out_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      mq_y.delete(); mq_o.delete(); mq_c.delete();
      m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (pop) begin
        void'(mq_y.pop_front()); void'(mq_o.pop_front()); void'(mq_c.pop_front());
      end
      if (acc) begin
        mq_y.push_back(m_store(in_y));
        mq_o.push_back(in_ovf);
        mq_c.push_back(m_class(in_y));
      end
      if (acc && in_ovf) begin
        m_sticky = 1;
        m_cnt  = flag_clr ? 1 : ((m_cnt  < 255) ? m_cnt  + 1 : 255);
        m_cnt2 = flag_clr ? 1 : ((m_cnt2 < 3)   ? m_cnt2 + 1 : 3);
      end else if (flag_clr) begin
        m_sticky = 0; m_cnt = 0; m_cnt2 = 0;
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_y = '0; in_ovf = 0; flag_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); out_ready = 0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_y !== 32'h0)     begin errors++; $display("FAIL reset_out_y: got %h expected 00000000", out_y); end
    checks++; if (out_ovf !== 1'b0)    begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
    checks++; if (out_cls !== 3'd0)    begin errors++; $display("FAIL reset_out_cls: got %0d expected 0", out_cls); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b expected 0", ovf_sticky); end
    checks++; if (ovf_cnt !== 8'd0)    begin errors++; $display("FAIL reset_cnt: got %0d expected 0", ovf_cnt); end
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 0;
  endtask

  task automatic test_single();
    out_ready = 1; in_valid = 1; in_y = 32'h3F800000; in_ovf = 0;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1)        begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_y !== 32'h3F800000)    begin errors++; $display("FAIL single_y: got %h expected 3f800000", out_y); end
    checks++; if (out_cls !== 3'd1)          begin errors++; $display("FAIL single_cls: got %0d expected 1", out_cls); end
    checks++; if (ovf_sticky !== 1'b0)       begin errors++; $display("FAIL single_sticky: got %b expected 0", ovf_sticky); end
    tick();
    checks++; if (out_valid !== 1'b0)        begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1; in_ovf = 0;
    in_y = 32'h00000000; tick();
    in_y = 32'h00000001; tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    in_y = 32'h7F800000; tick();
    checks++; if (in_ready !== 1'b0)       begin errors++; $display("FAIL bp_held_ready: got %b expected 0", in_ready); end
    checks++; if (out_y !== 32'h00000000)  begin errors++; $display("FAIL bp_held_y: got %h expected 00000000", out_y); end
    checks++; if (out_cls !== 3'd0)        begin errors++; $display("FAIL bp_cls0: got %0d expected 0", out_cls); end
    out_ready = 1; tick();
    checks++; if (out_y !== 32'h00000001)  begin errors++; $display("FAIL bp_second_y: got %h expected 00000001", out_y); end
    checks++; if (out_cls !== 3'd4)        begin errors++; $display("FAIL bp_cls4: got %0d expected 4", out_cls); end
    checks++; if (in_ready !== 1'b1)       begin errors++; $display("FAIL bp_ready_rise: got %b expected 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_y !== 32'h7F800000)  begin errors++; $display("FAIL bp_third_y: got %h expected 7f800000", out_y); end
    checks++; if (out_cls !== 3'd2)        begin errors++; $display("FAIL bp_cls2: got %0d expected 2", out_cls); end
    tick();
    checks++; if (out_valid !== 1'b0)      begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_ovf_flags();
    out_ready = 1; in_valid = 1; in_y = 32'h7F800000; in_ovf = 1;
    tick();
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf_sticky); end
    checks++; if (ovf_cnt !== 8'd1)    begin errors++; $display("FAIL ovf_cnt: got %0d expected 1", ovf_cnt); end
    checks++; if (out_ovf !== 1'b1)    begin errors++; $display("FAIL ovf_out: got %b expected 1", out_ovf); end
    flag_clr = 1;
    tick();
    idle_inputs();
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_clr_race_sticky: got %b expected 1", ovf_sticky); end
    checks++; if (ovf_cnt !== 8'd1)    begin errors++; $display("FAIL ovf_clr_race_cnt: got %0d expected 1", ovf_cnt); end
    tick();
  endtask

  task automatic test_saturation();
    flag_clr = 1; tick(); flag_clr = 0;
    out_ready = 1; in_valid = 1; in_y = 32'h7F800000; in_ovf = 1;
    repeat (5) tick();
    idle_inputs();
    checks++; if (s_ovf_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt_w2: got %0d expected 3", s_ovf_cnt); end
    checks++; if (ovf_cnt !== 8'd5)   begin errors++; $display("FAIL sat_cnt_w8: got %0d expected 5", ovf_cnt); end
    flag_clr = 1; tick(); flag_clr = 0;
    checks++; if (s_ovf_cnt !== 2'd0)     begin errors++; $display("FAIL sat_clr_cnt: got %0d expected 0", s_ovf_cnt); end
    checks++; if (s_ovf_sticky !== 1'b0)  begin errors++; $display("FAIL sat_clr_sticky: got %b expected 0", s_ovf_sticky); end
    tick();
  endtask

  task automatic test_nan();
    logic [31:0] exp_y;
`ifdef FMUL_NAN_CANON_EN
    exp_y = 32'h7FC00000;
`else
    exp_y = 32'hFFC00001;
`endif
    out_ready = 1; in_valid = 1; in_y = 32'hFFC00001; in_ovf = 0;
    tick();
    idle_inputs();
    checks++; if (out_y !== exp_y)  begin errors++; $display("FAIL nan_y: got %h expected %h", out_y, exp_y); end
    checks++; if (out_cls !== 3'd3) begin errors++; $display("FAIL nan_cls: got %0d expected 3", out_cls); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1; in_ovf = 1;
    in_y = 32'h40000000; tick();
    in_y = 32'h40400000; tick();
    rst = 1; tick();
    rst = 0; idle_inputs(); out_ready = 1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    checks++; if (ovf_cnt !== 8'd0)   begin errors++; $display("FAIL rstmid_cnt: got %0d expected 0", ovf_cnt); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got %b expected 0 at cycle %0d", out_valid, i); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] s, e, m;
      s = $urandom_range(0, 1);
      m = $urandom % (1 << 23);
      case ($urandom_range(0, 5))
        0: begin e = 0;   m = 0; end
        1: begin e = 0;   if (m == 0) m = 1; end
        2: begin e = 255; m = 0; end
        3: begin e = 255; if (m == 0) m = 5; end
        4: e = $urandom_range(1, 254);
        default: e = $urandom % 256;
      endcase
      rst       = ($urandom_range(0, 99) < 2);
      in_valid  = ($urandom_range(0, 99) < 65);
      in_y      = (s << 31) + (e << 23) + m;
      in_ovf    = ($urandom_range(0, 99) < 30);
      out_ready = ($urandom_range(0, 99) < 55);
      flag_clr  = ($urandom_range(0, 99) < 5);
      tick();
      checks++; if (in_ready !== ((mq_y.size() < 2) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL rnd_in_ready: got %b expected %b cycle %0d", in_ready, (mq_y.size() < 2), i); end
      checks++; if (out_valid !== ((mq_y.size() > 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL rnd_out_valid: got %b expected %b cycle %0d", out_valid, (mq_y.size() > 0), i); end
      if (mq_y.size() > 0) begin
        checks++; if (out_y !== mq_y[0])          begin errors++; $display("FAIL rnd_out_y: got %h expected %h cycle %0d", out_y, mq_y[0], i); end
        checks++; if (out_ovf !== mq_o[0])        begin errors++; $display("FAIL rnd_out_ovf: got %b expected %b cycle %0d", out_ovf, mq_o[0], i); end
        checks++; if (out_cls !== 3'(mq_c[0]))    begin errors++; $display("FAIL rnd_out_cls: got %0d expected %0d cycle %0d", out_cls, mq_c[0], i); end
      end
      checks++; if (ovf_sticky !== m_sticky)      begin errors++; $display("FAIL rnd_sticky: got %b expected %b cycle %0d", ovf_sticky, m_sticky, i); end
      checks++; if (ovf_cnt !== 8'(m_cnt))        begin errors++; $display("FAIL rnd_cnt: got %0d expected %0d cycle %0d", ovf_cnt, m_cnt, i); end
      checks++; if (s_ovf_cnt !== 2'(m_cnt2))     begin errors++; $display("FAIL rnd_cnt_w2: got %0d expected %0d cycle %0d", s_ovf_cnt, m_cnt2, i); end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1; out_ready = 0; idle_inputs();
    test_reset();
    test_single();
    test_backpressure();
    test_ovf_flags();
    test_saturation();
    test_nan();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
